// File: rtl/axi_read_master.sv
// axi_read_master: upstream read stage of a bridge port. It turns one CPU read
// request into a single AXI4 read transaction (AR, then R beats), returns each
// beat to the CPU and stalls the CPU until the final beat has been returned.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req, req_addr            CPU read request and byte address
//   stall                    CPU hold (combinational from req and state)
//   rdata, rdata_valid       returned beat, one-cycle pulse per beat
//   rd_last, rd_err          final-beat pulse and its error status
//   AR*                      AXI read address channel (master side)
//   R*, RREADY               AXI read data channel (master side)
module axi_read_master #(
  parameter logic [3:0]  ID          = 4'b0000,
  parameter int unsigned ADDR_BITS   = 32,
  parameter int unsigned DATA_BITS   = 32,
  parameter int unsigned BURST_BEATS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic [ADDR_BITS-1:0] req_addr,
  output logic                 stall,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 rdata_valid,
  output logic                 rd_last,
  output logic                 rd_err,
  output logic [3:0]           ARID,
  output logic [ADDR_BITS-1:0] ARADDR,
  output logic [3:0]           ARLEN,
  output logic [2:0]           ARSIZE,
  output logic [1:0]           ARBURST,
  output logic                 ARVALID,
  input  logic                 ARREADY,
  input  logic [3:0]           RID,
  input  logic [DATA_BITS-1:0] RDATA,
  input  logic [1:0]           RRESP,
  input  logic                 RLAST,
  input  logic                 RVALID,
  output logic                 RREADY
);

  // Wide enough to hold a count of 16 beats.
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] beat_cnt;
  logic             err_flag;
  logic             arvalid_next;
  logic             rready_next;

  logic launch_c;
  logic beat_c;
  logic count_done_c;
  logic final_c;
  logic beat_err_c;
  logic unused_c;

  assign ARID    = ID;
  assign ARLEN   = 4'(BURST_BEATS - 1);
  assign ARSIZE  = 3'b010;
  assign ARBURST = 2'b01;

  // The rd_last cycle belongs to the finished access, so it cannot launch.
  assign launch_c     = (state == IDLE) & req & ~rd_last;
  // Foreign-ID beats are handshaken but ignored here.
  assign beat_c       = (state == DATA) & RVALID & RREADY & (RID == ID);
  assign count_done_c = (beat_cnt + CNT_W'(1)) == CNT_W'(BURST_BEATS);
  assign final_c      = beat_c & (RLAST | count_done_c);
  // Bad response, or RLAST disagreeing with the beat count.
  assign beat_err_c   = (RRESP != 2'b00) | (RLAST != count_done_c);

  assign stall = (req | (state != IDLE)) & ~rd_last;

  // Byte offset bits are dropped by word alignment.
  assign unused_c = ^req_addr[1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (launch_c) state_next = ADDR;
      ADDR: if (ARVALID && ARREADY) state_next = DATA;
      DATA: if (final_c) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode; the AXI valid/ready flags are registered from it.
  always_comb begin
    arvalid_next = 1'b0;
    rready_next  = 1'b0;
    case (state_next)
      ADDR:    arvalid_next = 1'b1;
      DATA:    rready_next  = 1'b1;
      default: ;
    endcase
  end

  // Registered outputs, beat counter and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ARVALID     <= 1'b0;
      RREADY      <= 1'b0;
      ARADDR      <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      rd_last     <= 1'b0;
      rd_err      <= 1'b0;
      beat_cnt    <= '0;
      err_flag    <= 1'b0;
    end else begin
      ARVALID     <= arvalid_next;
      RREADY      <= rready_next;
      rdata_valid <= beat_c;
      rd_last     <= final_c;
      rd_err      <= final_c & (err_flag | beat_err_c);
      if (launch_c) begin
        ARADDR   <= {req_addr[ADDR_BITS-1:2], 2'b00};
        beat_cnt <= '0;
        err_flag <= 1'b0;
      end else if (beat_c) begin
        rdata    <= RDATA;
        beat_cnt <= beat_cnt + CNT_W'(1);
        if (beat_err_c) err_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_read_master.sv
// tb_axi_read_master: directed bench for axi_read_master. Instance u_a is a
// single-beat master, u_b a four-beat burst master; both share clk and rst.
module tb_axi_read_master;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // single-beat instance signals
  logic        a_req, a_stall, a_rdata_valid, a_rd_last, a_rd_err;
  logic [31:0] a_req_addr, a_rdata, a_araddr, a_rdata_in;
  logic [3:0]  a_arid, a_arlen, a_rid;
  logic [2:0]  a_arsize;
  logic [1:0]  a_arburst, a_rresp;
  logic        a_arvalid, a_arready, a_rlast, a_rvalid, a_rready;

  // burst instance signals
  logic        b_req, b_stall, b_rdata_valid, b_rd_last, b_rd_err;
  logic [31:0] b_req_addr, b_rdata, b_araddr, b_rdata_in;
  logic [3:0]  b_arid, b_arlen, b_rid;
  logic [2:0]  b_arsize;
  logic [1:0]  b_arburst, b_rresp;
  logic        b_arvalid, b_arready, b_rlast, b_rvalid, b_rready;

  axi_read_master #(.ID(4'b0000), .ADDR_BITS(32), .DATA_BITS(32), .BURST_BEATS(1)) u_a (
    .clk(clk), .rst(rst), .req(a_req), .req_addr(a_req_addr), .stall(a_stall),
    .rdata(a_rdata), .rdata_valid(a_rdata_valid), .rd_last(a_rd_last), .rd_err(a_rd_err),
    .ARID(a_arid), .ARADDR(a_araddr), .ARLEN(a_arlen), .ARSIZE(a_arsize),
    .ARBURST(a_arburst), .ARVALID(a_arvalid), .ARREADY(a_arready),
    .RID(a_rid), .RDATA(a_rdata_in), .RRESP(a_rresp), .RLAST(a_rlast),
    .RVALID(a_rvalid), .RREADY(a_rready)
  );

  axi_read_master #(.ID(4'b0000), .ADDR_BITS(32), .DATA_BITS(32), .BURST_BEATS(4)) u_b (
    .clk(clk), .rst(rst), .req(b_req), .req_addr(b_req_addr), .stall(b_stall),
    .rdata(b_rdata), .rdata_valid(b_rdata_valid), .rd_last(b_rd_last), .rd_err(b_rd_err),
    .ARID(b_arid), .ARADDR(b_araddr), .ARLEN(b_arlen), .ARSIZE(b_arsize),
    .ARBURST(b_arburst), .ARVALID(b_arvalid), .ARREADY(b_arready),
    .RID(b_rid), .RDATA(b_rdata_in), .RRESP(b_rresp), .RLAST(b_rlast),
    .RVALID(b_rvalid), .RREADY(b_rready)
  );

  // Returned beats of u_b, captured mid-cycle.
  typedef struct {
    logic [31:0] d;
    logic        l;
    logic        e;
  } beat_t;
  beat_t q[$];

  always @(negedge clk) begin
    if (b_rdata_valid) q.push_back('{b_rdata, b_rd_last, b_rd_err});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic b_launch(input logic [31:0] addr, input logic [31:0] exp_araddr);
    b_req      = 1'b1;
    b_req_addr = addr;
    b_arready  = 1'b1;
    step();
    check("b_arvalid", 64'(b_arvalid), 64'(1));
    check("b_araddr", 64'(b_araddr), 64'(exp_araddr));
    step();
    check("b_rready", 64'(b_rready), 64'(1));
  endtask

  task automatic b_beat(input int gap, input logic [31:0] d, input logic [1:0] resp,
                        input logic last, input logic [3:0] id);
    b_rvalid = 1'b0;
    repeat (gap) step();
    b_rvalid   = 1'b1;
    b_rdata_in = d;
    b_rresp    = resp;
    b_rlast    = last;
    b_rid      = id;
    step();
    b_rvalid = 1'b0;
    b_rlast  = 1'b0;
    b_rresp  = 2'b00;
    b_rid    = 4'b0000;
  endtask

  // Called in the rd_last cycle: releases the CPU and returns to idle.
  task automatic b_finish(input string tag);
    check({tag, "_stall_release"}, 64'(b_stall), 64'(0));
    b_req = 1'b0;
    step();
    check({tag, "_idle_arvalid"}, 64'(b_arvalid), 64'(0));
    check({tag, "_idle_rready"}, 64'(b_rready), 64'(0));
  endtask

  task automatic expect_beat(input int idx, input logic [31:0] d, input logic l, input logic e);
    if (idx < q.size()) begin
      check($sformatf("beat%0d_data", idx), 64'(q[idx].d), 64'(d));
      check($sformatf("beat%0d_last", idx), 64'(q[idx].l), 64'(l));
      check($sformatf("beat%0d_err", idx), 64'(q[idx].e), 64'(e));
    end else begin
      check($sformatf("beat%0d_missing", idx), 64'(q.size()), 64'(idx + 1));
    end
  endtask

  task automatic b_normal_burst(input string tag, input logic [31:0] base);
    q.delete();
    b_launch(base, base);
    b_beat(0, base + 32'h1, 2'b00, 1'b0, 4'h0);
    b_beat(0, base + 32'h2, 2'b00, 1'b0, 4'h0);
    b_beat(0, base + 32'h3, 2'b00, 1'b0, 4'h0);
    b_beat(0, base + 32'h4, 2'b00, 1'b1, 4'h0);
    b_finish(tag);
    check({tag, "_count"}, 64'(q.size()), 64'(4));
    expect_beat(3, base + 32'h4, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    a_req = 1'b0; a_req_addr = '0; a_arready = 1'b0; a_rid = '0;
    a_rdata_in = '0; a_rresp = '0; a_rlast = 1'b0; a_rvalid = 1'b0;
    b_req = 1'b0; b_req_addr = '0; b_arready = 1'b0; b_rid = '0;
    b_rdata_in = '0; b_rresp = '0; b_rlast = 1'b0; b_rvalid = 1'b0;
    repeat (2) step();

    // Reset state
    check("rst_a_arvalid", 64'(a_arvalid), 64'(0));
    check("rst_a_rready", 64'(a_rready), 64'(0));
    check("rst_a_rdata_valid", 64'(a_rdata_valid), 64'(0));
    check("rst_a_rd_last", 64'(a_rd_last), 64'(0));
    check("rst_a_rd_err", 64'(a_rd_err), 64'(0));
    check("rst_a_rdata", 64'(a_rdata), 64'(0));
    check("rst_a_araddr", 64'(a_araddr), 64'(0));
    check("rst_a_stall", 64'(a_stall), 64'(0));
    check("rst_b_arvalid", 64'(b_arvalid), 64'(0));
    check("rst_b_rready", 64'(b_rready), 64'(0));
    rst = 1'b0;
    step();

    // Single beat, zero wait: cycle 0 request
    a_req = 1'b1; a_req_addr = 32'h0000_1006; a_arready = 1'b1;
    #1;
    check("t1_c0_stall", 64'(a_stall), 64'(1));
    step(); // cycle 1
    check("t1_c1_arvalid", 64'(a_arvalid), 64'(1));
    check("t1_c1_araddr", 64'(a_araddr), 64'(32'h0000_1004));
    check("t1_c1_arlen", 64'(a_arlen), 64'(0));
    check("t1_c1_arid", 64'(a_arid), 64'(0));
    check("t1_c1_arsize", 64'(a_arsize), 64'(2));
    check("t1_c1_arburst", 64'(a_arburst), 64'(1));
    check("t1_c1_stall", 64'(a_stall), 64'(1));
    step(); // cycle 2
    check("t1_c2_rready", 64'(a_rready), 64'(1));
    check("t1_c2_arvalid", 64'(a_arvalid), 64'(0));
    check("t1_c2_stall", 64'(a_stall), 64'(1));
    a_rvalid = 1'b1; a_rdata_in = 32'hDEAD_BEEF; a_rlast = 1'b1; a_rid = 4'h0;
    step(); // cycle 3
    a_rvalid = 1'b0; a_rlast = 1'b0;
    check("t1_c3_rdata", 64'(a_rdata), 64'(32'hDEAD_BEEF));
    check("t1_c3_rdata_valid", 64'(a_rdata_valid), 64'(1));
    check("t1_c3_rd_last", 64'(a_rd_last), 64'(1));
    check("t1_c3_rd_err", 64'(a_rd_err), 64'(0));
    check("t1_c3_stall", 64'(a_stall), 64'(0));
    check("t1_c3_rready", 64'(a_rready), 64'(0));
    step(); // cycle 4: req still high from the finished access, no relaunch
    check("t1_c4_no_relaunch", 64'(a_arvalid), 64'(0));
    check("t1_c4_rdata_valid", 64'(a_rdata_valid), 64'(0));

    // AR backpressure: req kept high is a new request, launched at cycle 4
    a_req_addr = 32'h0000_2002; a_arready = 1'b0;
    step();
    a_req_addr = 32'h0000_3333;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_hold%0d_arvalid", i), 64'(a_arvalid), 64'(1));
      check($sformatf("t2_hold%0d_araddr", i), 64'(a_araddr), 64'(32'h0000_2000));
      check($sformatf("t2_hold%0d_rready", i), 64'(a_rready), 64'(0));
      step();
    end
    check("t2_arvalid_still", 64'(a_arvalid), 64'(1));
    a_arready = 1'b1;
    step();
    a_arready = 1'b0;
    check("t2_rready", 64'(a_rready), 64'(1));
    check("t2_arvalid_drop", 64'(a_arvalid), 64'(0));
    a_rvalid = 1'b1; a_rdata_in = 32'hCAFE_F00D; a_rlast = 1'b1;
    step();
    a_rvalid = 1'b0; a_rlast = 1'b0;
    check("t2_rdata", 64'(a_rdata), 64'(32'hCAFE_F00D));
    check("t2_rd_last", 64'(a_rd_last), 64'(1));
    check("t2_rd_err", 64'(a_rd_err), 64'(0));
    a_req = 1'b0;
    step();

    // Burst with RVALID gaps 0/2/1/0
    q.delete();
    b_launch(32'h0000_0100, 32'h0000_0100);
    check("t3_arlen", 64'(b_arlen), 64'(3));
    b_beat(0, 32'h11, 2'b00, 1'b0, 4'h0);
    check("t3_mid_stall", 64'(b_stall), 64'(1));
    check("t3_mid_rd_last", 64'(b_rd_last), 64'(0));
    b_beat(2, 32'h22, 2'b00, 1'b0, 4'h0);
    b_beat(1, 32'h33, 2'b00, 1'b0, 4'h0);
    b_beat(0, 32'h44, 2'b00, 1'b1, 4'h0);
    b_finish("t3");
    check("t3_count", 64'(q.size()), 64'(4));
    expect_beat(0, 32'h11, 1'b0, 1'b0);
    expect_beat(1, 32'h22, 1'b0, 1'b0);
    expect_beat(2, 32'h33, 1'b0, 1'b0);
    expect_beat(3, 32'h44, 1'b1, 1'b0);

    // SLVERR on beat 2 of 4
    q.delete();
    b_launch(32'h0000_0204, 32'h0000_0204);
    b_beat(0, 32'hA1, 2'b00, 1'b0, 4'h0);
    b_beat(0, 32'hA2, 2'b10, 1'b0, 4'h0);
    b_beat(0, 32'hA3, 2'b00, 1'b0, 4'h0);
    b_beat(0, 32'hA4, 2'b00, 1'b1, 4'h0);
    b_finish("t4");
    check("t4_count", 64'(q.size()), 64'(4));
    expect_beat(1, 32'hA2, 1'b0, 1'b0);
    expect_beat(3, 32'hA4, 1'b1, 1'b1);

    // Early RLAST on beat 2
    q.delete();
    b_launch(32'h0000_0300, 32'h0000_0300);
    b_beat(0, 32'hB1, 2'b00, 1'b0, 4'h0);
    b_beat(0, 32'hB2, 2'b00, 1'b1, 4'h0);
    b_finish("t5");
    check("t5_count", 64'(q.size()), 64'(2));
    expect_beat(1, 32'hB2, 1'b1, 1'b1);

    // Count reached without RLAST
    q.delete();
    b_launch(32'h0000_0310, 32'h0000_0310);
    b_beat(0, 32'hC1, 2'b00, 1'b0, 4'h0);
    b_beat(0, 32'hC2, 2'b00, 1'b0, 4'h0);
    b_beat(0, 32'hC3, 2'b00, 1'b0, 4'h0);
    b_beat(0, 32'hC4, 2'b00, 1'b0, 4'h0);
    b_finish("t6");
    check("t6_count", 64'(q.size()), 64'(4));
    expect_beat(3, 32'hC4, 1'b1, 1'b1);

    // Foreign ID beat mid-burst
    q.delete();
    b_launch(32'h0000_0400, 32'h0000_0400);
    b_beat(0, 32'h11, 2'b00, 1'b0, 4'h0);
    b_beat(0, 32'h22, 2'b00, 1'b0, 4'h0);
    b_beat(0, 32'h99, 2'b00, 1'b1, 4'h1);
    check("t7_foreign_rdata", 64'(b_rdata), 64'(32'h22));
    check("t7_foreign_valid", 64'(b_rdata_valid), 64'(0));
    check("t7_foreign_rready", 64'(b_rready), 64'(1));
    b_beat(0, 32'h33, 2'b00, 1'b0, 4'h0);
    b_beat(0, 32'h44, 2'b00, 1'b1, 4'h0);
    b_finish("t7");
    check("t7_count", 64'(q.size()), 64'(4));
    expect_beat(2, 32'h33, 1'b0, 1'b0);
    expect_beat(3, 32'h44, 1'b1, 1'b0);

    // Reset while in ADDR
    b_req = 1'b1; b_req_addr = 32'h0000_0500; b_arready = 1'b0;
    step();
    check("t8_addr_arvalid", 64'(b_arvalid), 64'(1));
    rst = 1'b1;
    step();
    check("t8_rst_arvalid", 64'(b_arvalid), 64'(0));
    check("t8_rst_rready", 64'(b_rready), 64'(0));
    check("t8_rst_stall", 64'(b_stall), 64'(1));
    rst = 1'b0; b_req = 1'b0;
    #1;
    check("t8_idle_stall", 64'(b_stall), 64'(0));
    step();
    check("t8_no_launch", 64'(b_arvalid), 64'(0));
    b_normal_burst("t8_after", 32'h0000_0600);

    // Reset while in DATA
    b_launch(32'h0000_0700, 32'h0000_0700);
    b_beat(0, 32'h55, 2'b00, 1'b0, 4'h0);
    rst = 1'b1;
    step();
    check("t9_rst_arvalid", 64'(b_arvalid), 64'(0));
    check("t9_rst_rready", 64'(b_rready), 64'(0));
    check("t9_rst_stall", 64'(b_stall), 64'(1));
    check("t9_rst_rdata_valid", 64'(b_rdata_valid), 64'(0));
    rst = 1'b0; b_req = 1'b0;
    step();
    b_normal_burst("t9_after", 32'h0000_0800);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_read_master.md
Name: axi_read_master

Overview:
- Upstream master stage for a bridge read port: turns a CPU-side read request into one AXI4 read transaction (AR then R) and returns the data beats to the CPU.
- Holds the CPU with a stall until the final beat has been returned.
- One instance per read-capable master: instruction fetch on M0, data load on M1.

Parameters:
ID, 4'b0000, constant driven on ARID; only R beats whose RID matches are consumed
ADDR_BITS, 32, address width
DATA_BITS, 32, data width
BURST_BEATS, 1, beats per transaction (1..16); ARLEN = BURST_BEATS-1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  1  CPU read request; held high until the stall releases
req_addr  in  ADDR_BITS  CPU byte address, sampled at request launch
stall  out  1  CPU hold
rdata  out  DATA_BITS  returned beat
rdata_valid  out  1  one-cycle pulse per returned beat
rd_last  out  1  pulse with the final rdata_valid of a transaction
rd_err  out  1  pulse with rd_last when the transaction had an error
ARID  out  4  = ID
ARADDR  out  ADDR_BITS  word-aligned latched address
ARLEN  out  4  = BURST_BEATS-1
ARSIZE  out  3  = 3'b010
ARBURST  out  2  = 2'b01 (INCR)
ARVALID  out  1  address valid
ARREADY  in  1  address ready
RID  in  4  read ID
RDATA  in  DATA_BITS  read data
RRESP  in  2  read response
RLAST  in  1  last beat
RVALID  in  1  read valid
RREADY  out  1  read ready

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high.
- Reset values:
  - state = IDLE.
  - ARVALID, RREADY, rdata_valid, rd_last and rd_err = 0.
  - rdata and ARADDR = 0.
  - Beat counter and error flag cleared.
- Reset mid-transaction aborts to IDLE on the next edge. The bridge shares the same reset, so no AXI recovery is needed.
- FSM:
  - IDLE -> ADDR when req=1 and rd_last=0. In that cycle ARADDR <= {req_addr[ADDR_BITS-1:2],2'b00}; the counter and error flag are cleared.
  - ADDR: ARVALID=1. The ARADDR/ARLEN/ARSIZE/ARBURST payload is stable until ARREADY. On ARVALID&ARREADY -> DATA. ARVALID never drops before the handshake.
  - DATA: RREADY=1.
    - Each RVALID&RREADY with RID==ID is a beat: rdata <= RDATA; rdata_valid pulses the next cycle; counter increments.
    - Any beat with RRESP!=2'b00 sets the error flag.
    - Beats with RID!=ID are accepted (RREADY stays high) but discarded and not counted.
  - DATA -> IDLE on a matching beat that has RLAST=1, or that is beat number BURST_BEATS.
  - If RLAST and the count disagree (early RLAST, or the count is reached without RLAST), the transaction completes and the error flag is set.
- Completion: the cycle after the final beat, rdata_valid=1, rd_last=1, rd_err=error flag.
- stall = (req | state!=IDLE) & ~rd_last. It is combinational from req and registered state.
- The rd_last cycle releases the CPU. req seen in that cycle belongs to the finished access and does not launch a new one.
- req_addr changes after launch are ignored.
- Minimum single-beat latency with ARREADY and RVALID both immediate:
  - req high at cycle 0.
  - ARVALID at cycle 1.
  - RREADY at cycle 2.
  - rdata_valid/rd_last at cycle 3.
- Back-to-back: a new launch is possible at the earliest 1 cycle after the rd_last cycle.

Test Plan:
- Single beat, zero-wait: req=1, req_addr=0x0000_1006, ARREADY=1 -> ARADDR=0x0000_1004 and ARLEN=0 at cycle 1. Slave returns RDATA=0xDEADBEEF, RLAST=1, RID=0 -> rdata=0xDEADBEEF, rdata_valid=rd_last=1 at cycle 3, rd_err=0; stall low only that cycle.
- AR backpressure: hold ARREADY=0 for 5 cycles -> ARVALID stays high and ARADDR stays constant; R phase starts the cycle after ARREADY.
- Burst, BURST_BEATS=4: beats 0x11/0x22/0x33/0x44, with RVALID gaps of 0/2/1/0 cycles -> four rdata_valid pulses in order; rd_last only with 0x44.
- Error cases:
  - RRESP=2'b10 on beat 2 of 4 -> rd_err=1 with rd_last.
  - Early RLAST on beat 2 -> completion after 2 beats, rd_err=1.
- Foreign ID: a beat with RID=4'b0001 inserted mid-burst -> discarded; count and rdata unchanged.
- Reset: assert rst while in ADDR, and separately while in DATA -> next cycle ARVALID=0, RREADY=0, stall=req, state IDLE; a later request completes normally.
